cluster_clock_gate_ctrl: RTL and testbench

- Multi-channel automatic clock-gating controller for cluster sub-domains (cores, DMA, HWPE, shared FPU).
- Per channel: watches activity, closes the clock after a programmable idle hysteresis, and reopens it on demand.
- Wake-up uses a req/ack handshake so that requesters know when the gated clock is stable.
- Drives one leaf gating cell per channel and keeps per-channel gated-cycle statistics for power profiling.

---
 rtl/cluster_cg_pkg.sv | 18 +
 rtl/cluster_cg_chan.sv | 115 +++++++++++
 rtl/cluster_clock_gating.sv | 21 ++
 rtl/cluster_clock_gate_ctrl.sv | 55 +++++
 tb/tb_cluster_clock_gate_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_cg_pkg.sv
// Shared types and default sizing for the cluster clock-gating controller.
// Imported by the per-channel FSM and the top-level controller.
package cluster_cg_pkg;

    // Per-channel gating FSM states.
    typedef enum logic [1:0] {
        CG_ON   = 2'd0,
        CG_IDLE = 2'd1,
        CG_OFF  = 2'd2,
        CG_WAKE = 2'd3
    } cg_state_e;

    localparam int unsigned CG_NB_CH    = 4;
    localparam int unsigned CG_HYST_W   = 8;
    localparam int unsigned CG_WAKE_CYC = 2;
    localparam int unsigned CG_CNT_W    = 16;

endpackage

// File: rtl/cluster_cg_chan.sv
// One gating channel: ON/IDLE/OFF/WAKE FSM, hysteresis and wake counters, gated-cycle stats.
// Ports: wake_i activity, hyst_i idle threshold, clr_cnt_i stats clear; en_o/ack_o/gated_o/gated_cnt_o registered.
module cluster_cg_chan
    import cluster_cg_pkg::*;
#(
    parameter int unsigned HYST_W   = CG_HYST_W,
    parameter int unsigned WAKE_CYC = CG_WAKE_CYC,
    parameter int unsigned CNT_W    = CG_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wake_i,
    input  logic [HYST_W-1:0] hyst_i,
    input  logic             clr_cnt_i,
    output logic             en_o,
    output logic             ack_o,
    output logic             gated_o,
    output logic [CNT_W-1:0] gated_cnt_o
);

    localparam int unsigned WK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    // WAKE lasts WAKE_CYC cycles, so the counter starts one below that.
    localparam logic [WK_W-1:0] WK_LOAD =
        (WAKE_CYC > 0) ? WK_W'(WAKE_CYC - 1) : '0;

    cg_state_e         state_q, state_d;
    logic [HYST_W-1:0] hyst_q, hyst_d;
    logic [WK_W-1:0]   wk_q, wk_d;
    logic              en_q, ack_q, gated_q;
    logic              en_d, ack_d, gated_d;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        state_d = state_q;
        hyst_d  = hyst_q;
        wk_d    = wk_q;
        unique case (state_q)
            CG_ON: begin
                if (!wake_i) begin
                    state_d = CG_IDLE;
                    hyst_d  = hyst_i;
                end
            end
            CG_IDLE: begin
                if (wake_i) begin
                    state_d = CG_ON;
                end else if (hyst_q == '0) begin
                    state_d = CG_OFF;
                end else begin
                    hyst_d = hyst_q - 1'b1;
                end
            end
            CG_OFF: begin
                if (wake_i) begin
                    if (WAKE_CYC == 0) begin
                        state_d = CG_ON;
                    end else begin
                        state_d = CG_WAKE;
                        wk_d    = WK_LOAD;
                    end
                end
            end
            CG_WAKE: begin
                // Completes regardless of wake_i so a 1-cycle pulse suffices.
                if (wk_q == '0) begin
                    state_d = CG_ON;
                end else begin
                    wk_d = wk_q - 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from the next state.
    always_comb begin
        en_d    = (state_d != CG_OFF);
        ack_d   = (state_d == CG_ON) || (state_d == CG_IDLE);
        gated_d = (state_d == CG_OFF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CG_ON;
            hyst_q  <= '0;
            wk_q    <= '0;
            en_q    <= 1'b1;
            ack_q   <= 1'b0;
            gated_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hyst_q  <= hyst_d;
            wk_q    <= wk_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            gated_q <= gated_d;
        end
    end

    // Saturating gated-cycle counter; clear wins over increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_cnt_i) begin
            cnt_q <= '0;
        end else if ((state_q == CG_OFF) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign en_o        = en_q;
    assign ack_o       = ack_q;
    assign gated_o     = gated_q;
    assign gated_cnt_o = cnt_q;

endmodule

// File: rtl/cluster_clock_gating.sv
// Leaf clock-gating cell: latch-based enable, transparent while clk_i is low.
// Ports: clk_i ungated clock, en_i functional enable, test_en_i scan override, clk_o gated clock.
module cluster_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    // Enable can only change while clk_i is low, so clk_o never glitches.
    always_latch begin
        if (!clk_i) begin
            en_latch = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/cluster_clock_gate_ctrl.sv
// Multi-channel automatic clock-gating controller with req/ack wake handshake and stats.
// Ports: busy_i/req_i/force_on_i per-channel wake sources, hyst_i idle threshold; clk_o/ack_o/gated_o/gated_cnt_o per channel.
module cluster_clock_gate_ctrl
    import cluster_cg_pkg::*;
#(
    parameter int unsigned NB_CH    = CG_NB_CH,
    parameter int unsigned HYST_W   = CG_HYST_W,
    parameter int unsigned WAKE_CYC = CG_WAKE_CYC,
    parameter int unsigned CNT_W    = CG_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_en_i,
    input  logic [NB_CH-1:0]       busy_i,
    input  logic [NB_CH-1:0]       req_i,
    input  logic [NB_CH-1:0]       force_on_i,
    input  logic [HYST_W-1:0]      hyst_i,
    input  logic                   clr_cnt_i,
    output logic [NB_CH-1:0]       clk_o,
    output logic [NB_CH-1:0]       ack_o,
    output logic [NB_CH-1:0]       gated_o,
    output logic [NB_CH*CNT_W-1:0] gated_cnt_o
);

    logic [NB_CH-1:0] wake;
    logic [NB_CH-1:0] en;

    assign wake = busy_i | req_i | force_on_i;

    for (genvar ch = 0; ch < NB_CH; ch++) begin : g_ch
        cluster_cg_chan #(
            .HYST_W   (HYST_W),
            .WAKE_CYC (WAKE_CYC),
            .CNT_W    (CNT_W)
        ) i_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .wake_i      (wake[ch]),
            .hyst_i      (hyst_i),
            .clr_cnt_i   (clr_cnt_i),
            .en_o        (en[ch]),
            .ack_o       (ack_o[ch]),
            .gated_o     (gated_o[ch]),
            .gated_cnt_o (gated_cnt_o[ch*CNT_W +: CNT_W])
        );

        cluster_clock_gating i_cg (
            .clk_i     (clk_i),
            .en_i      (en[ch]),
            .test_en_i (test_en_i),
            .clk_o     (clk_o[ch])
        );
    end

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Testbench for cluster_clock_gate_ctrl: vector table, directed corner cases, random vs model.
// Two instances: default sizing, and WAKE_CYC=0 / CNT_W=4 for the zero-wake and saturation corners.
module tb_cluster_clock_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst, test_en, clr;
    logic [3:0]  busy, req, force_on;
    logic [7:0]  hyst;

    logic [3:0]  a_clk, a_ack, a_gated;
    logic [63:0] a_cnt;
    logic [3:0]  b_clk, b_ack, b_gated;
    logic [15:0] b_cnt;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    cluster_clock_gate_ctrl dut_a (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
        .busy_i(busy), .req_i(req), .force_on_i(force_on),
        .hyst_i(hyst), .clr_cnt_i(clr),
        .clk_o(a_clk), .ack_o(a_ack), .gated_o(a_gated),
        .gated_cnt_o(a_cnt)
    );

    cluster_clock_gate_ctrl #(
        .NB_CH(4), .HYST_W(8), .WAKE_CYC(0), .CNT_W(4)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
        .busy_i(busy), .req_i(req), .force_on_i(force_on),
        .hyst_i(hyst), .clr_cnt_i(clr),
        .clk_o(b_clk), .ack_o(b_ack), .gated_o(b_gated),
        .gated_cnt_o(b_cnt)
    );

    // Reference model: channel is either running or gated; when running it
    // counts the current streak of wake-free edges and gates once the streak
    // reaches the threshold (latched at streak start) plus two. Leaving the
    // gated condition takes wc further edges before the clock is declared stable.
    int m_gated [2][4];
    int m_pg    [2][4];
    int m_rem   [2][4];
    int m_run   [2][4];
    int m_h     [2][4];
    int m_ack   [2][4];
    int m_cnt   [2][4];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4; c++) begin
                int wc, mx;
                bit w;
                wc = (i == 0) ? 2 : 0;
                mx = (i == 0) ? 65535 : 15;
                w = busy[c] | req[c] | force_on[c];
                m_pg[i][c] = m_gated[i][c];
                if (rst) begin
                    m_gated[i][c] = 0; m_rem[i][c] = 0; m_run[i][c] = 0;
                    m_ack[i][c] = 0; m_cnt[i][c] = 0;
                    continue;
                end
                if (clr) m_cnt[i][c] = 0;
                else if (m_gated[i][c] != 0 && m_cnt[i][c] < mx)
                    m_cnt[i][c]++;
                if (m_gated[i][c] != 0) begin
                    if (w) begin
                        m_gated[i][c] = 0;
                        m_rem[i][c] = wc;
                        m_ack[i][c] = (wc == 0);
                        m_run[i][c] = 0;
                    end
                end else if (m_rem[i][c] > 0) begin
                    m_rem[i][c]--;
                    if (m_rem[i][c] == 0) m_ack[i][c] = 1;
                end else begin
                    m_ack[i][c] = 1;
                    if (w) m_run[i][c] = 0;
                    else begin
                        m_run[i][c]++;
                        if (m_run[i][c] == 1) m_h[i][c] = int'(hyst);
                        if (m_run[i][c] >= m_h[i][c] + 2) begin
                            m_gated[i][c] = 1;
                            m_ack[i][c] = 0;
                            m_run[i][c] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s a ack%0d", tag, c), 32'(a_ack[c]), 32'(m_ack[0][c]));
            chk($sformatf("%s a gated%0d", tag, c), 32'(a_gated[c]), 32'(m_gated[0][c]));
            chk($sformatf("%s a cnt%0d", tag, c), 32'(a_cnt[c*16 +: 16]), 32'(m_cnt[0][c]));
            chk($sformatf("%s a clk%0d", tag, c), 32'(a_clk[c]),
                32'((m_pg[0][c] == 0) || test_en));
            chk($sformatf("%s b ack%0d", tag, c), 32'(b_ack[c]), 32'(m_ack[1][c]));
            chk($sformatf("%s b gated%0d", tag, c), 32'(b_gated[c]), 32'(m_gated[1][c]));
            chk($sformatf("%s b cnt%0d", tag, c), 32'(b_cnt[c*4 +: 4]), 32'(m_cnt[1][c]));
            chk($sformatf("%s b clk%0d", tag, c), 32'(b_clk[c]),
                32'((m_pg[1][c] == 0) || test_en));
        end
    endtask

    typedef struct {
        logic [3:0]  busy;
        logic [3:0]  req;
        logic        ack0;
        logic        gated0;
        logic        clk0;
        logic [15:0] cnt0;
    } vec_t;

    vec_t vec [12];

    initial begin
        int ng, nc;
        // Reset release with hyst=3, then a 1-cycle req pulse into OFF on ch0.
        vec[0]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd0};
        vec[1]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd0};
        vec[2]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd0};
        vec[3]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd0};
        vec[4]  = '{4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'd0};
        vec[5]  = '{4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd1};
        vec[6]  = '{4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'd2};
        vec[7]  = '{4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 16'd3};
        vec[8]  = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'd3};
        vec[9]  = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd3};
        vec[10] = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd3};
        vec[11] = '{4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 16'd3};

        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                m_gated[i][c] = 0; m_pg[i][c] = 0; m_rem[i][c] = 0;
                m_run[i][c] = 0; m_h[i][c] = 0; m_ack[i][c] = 0;
                m_cnt[i][c] = 0;
            end

        rst = 1'b1; test_en = 1'b0; clr = 1'b0;
        busy = '0; req = '0; force_on = '0; hyst = 8'd3;
        tick(); tick(); tick();
        chk("reset ack", 32'(a_ack), 32'h0);
        chk("reset gated", 32'(a_gated), 32'h0);
        chk("reset clk", 32'(a_clk), 32'hf);
        chk("reset cnt lo", a_cnt[31:0], 32'h0);
        chk("reset cnt hi", a_cnt[63:32], 32'h0);

        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            busy = vec[k].busy;
            req  = vec[k].req;
            tick();
            chk($sformatf("vec%0d ack0", k + 1), 32'(a_ack[0]), 32'(vec[k].ack0));
            chk($sformatf("vec%0d gated0", k + 1), 32'(a_gated[0]), 32'(vec[k].gated0));
            chk($sformatf("vec%0d clk0", k + 1), 32'(a_clk[0]), 32'(vec[k].clk0));
            chk($sformatf("vec%0d cnt0", k + 1), 32'(a_cnt[15:0]), 32'(vec[k].cnt0));
        end
        cmp_model("post-table");

        // Ch1: wake in IDLE with hysteresis counter at 0 keeps it clocked.
        busy = 4'h2;
        repeat (4) tick();
        chk("ch1 woken ack", 32'(a_ack[1]), 32'h1);
        hyst = 8'd0; busy = 4'h0;
        tick();
        chk("ch1 idle0 gated", 32'(a_gated[1]), 32'h0);
        chk("ch1 idle0 ack", 32'(a_ack[1]), 32'h1);
        busy = 4'h2;
        tick();
        chk("ch1 prio gated", 32'(a_gated[1]), 32'h0);
        chk("ch1 prio clk", 32'(a_clk[1]), 32'h1);
        busy = 4'h0;
        tick();
        chk("ch1 hyst0 idle", 32'(a_gated[1]), 32'h0);
        tick();
        chk("ch1 hyst0 off", 32'(a_gated[1]), 32'h1);
        chk("ch1 hyst0 ack", 32'(a_ack[1]), 32'h0);

        // Ch2 held on by force for 1000 cycles; ch3 keeps gating.
        clr = 1'b1; force_on = 4'h4;
        tick();
        clr = 1'b0;
        ng = 0; nc = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (a_gated[2]) ng++;
            if (!a_clk[2] && k > 2) nc++;
        end
        chk("force ch2 gated cycles", 32'(ng), 32'd0);
        chk("force ch2 clk stops", 32'(nc), 32'd0);
        chk("force ch2 cnt", 32'(a_cnt[47:32]), 32'd0);
        chk("force ch3 cnt", 32'(a_cnt[63:48]), 32'd1000);
        chk("b ch3 saturated", 32'(b_cnt[15:12]), 32'd15);
        cmp_model("force");

        // Clear together with an OFF cycle.
        force_on = 4'h0; clr = 1'b1;
        tick();
        chk("clr a ch3", 32'(a_cnt[63:48]), 32'd0);
        chk("clr b ch3", 32'(b_cnt[15:12]), 32'd0);
        clr = 1'b0;
        tick();
        chk("post-clr a ch3", 32'(a_cnt[63:48]), 32'd1);
        chk("post-clr b ch3", 32'(b_cnt[15:12]), 32'd1);

        // Scan mode with every channel gated.
        repeat (10) tick();
        chk("all off", 32'(a_gated), 32'hf);
        test_en = 1'b1;
        tick();
        chk("test clk high", 32'(a_clk), 32'hf);
        chk("test gated", 32'(a_gated), 32'hf);
        chk("test ack", 32'(a_ack), 32'h0);
        @(negedge clk); #1;
        chk("test clk low", 32'(a_clk), 32'h0);
        tick();
        chk("test clk high2", 32'(a_clk), 32'hf);
        test_en = 1'b0;
        tick();
        cmp_model("test_en");

        // Reset in the middle of WAKE.
        req = 4'h1;
        tick();
        chk("wake ack", 32'(a_ack[0]), 32'h0);
        chk("wake gated", 32'(a_gated[0]), 32'h0);
        req = 4'h0; rst = 1'b1;
        tick();
        chk("rst-wake ack", 32'(a_ack[0]), 32'h0);
        chk("rst-wake gated", 32'(a_gated), 32'h0);
        chk("rst-wake cnt", a_cnt[31:0], 32'h0);
        tick();
        chk("rst-wake clk", 32'(a_clk), 32'hf);
        rst = 1'b0;
        tick();
        chk("rst-wake release ack", 32'(a_ack), 32'hf);

        // Random phase against the model.
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < 4; c++) begin
                busy[c]     = ($urandom_range(0, 6) == 0);
                req[c]      = ($urandom_range(0, 19) == 0);
                force_on[c] = ($urandom_range(0, 59) == 0);
            end
            hyst    = 8'($urandom_range(0, 4));
            clr     = ($urandom_range(0, 99) == 0);
            test_en = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            tick();
            cmp_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
